tcbm_device_link: RTL and testbench
===================================

# tcbm_device_link

Device-side TCBM link engine for the 1551-style paddle. It sits directly downstream of the fake 6523 TPI port pins and plays the drive role. It decodes the computer's two-byte command/data handshakes on PA/DAV, answers with ACK and the ST1:ST0 status lines, and buffers traffic toward the storage backend through small receive and transmit FIFOs.

## Interface
Parameters:
- DEPTH_LOG2, 2: log2 of the RX and TX FIFO depth; both FIFOs are 4 entries by default.
- SETUP, 4: clock cycles PA/ST are driven before ACK falls in a transmit phase.
- TIMEOUT, 65535: clock cycles to wait for the next DAV edge before aborting to IDLE.

Ports:
- clock  in  1  single system clock.
- _reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- pa_in  in  8  TPI port A pins as seen by the device.
- pa_out  out  8  data the device drives onto port A.
- pa_oe  out  1  port A output enable; 1 = device drives PA.
- dav_n  in  1  DAV from the computer (TPI PC6), asynchronous, active-low.
- ack_n  out  1  ACK to the computer (TPI PC7), active-low.
- st  out  2  ST1:ST0 status lines (TPI PB1:PB0).
- rx_data  out  8  head byte of the RX FIFO.
- rx_cmd  out  1  head-entry tag; 1 = command/secondary byte, 0 = data byte.
- rx_valid  out  1  RX FIFO is non-empty.
- rx_ready  in  1  backend pop; an entry is popped when rx_valid & rx_ready.
- tx_data  in  8  byte for the computer.
- tx_eoi  in  1  marks tx_data as the last byte.
- tx_valid  in  1  backend push request.
- tx_ready  out  1  TX FIFO is not full; an entry is pushed when tx_valid & tx_ready.
- busy  out  1  1 when the state machine is not in IDLE.

## Operation
- dav_n passes through a 2-flop synchronizer; `dav_s` is the synchronized, active-high DAV. All protocol decisions use `dav_s` only.
- Handshake is 4-phase, in this order:
  - computer sets PA, then DAV goes low;
  - device asserts ACK low;
  - computer releases DAV high;
  - device releases ACK high.
- Every transaction is a code byte followed by one data phase.
- Code bytes:
  - 0x81: the next byte is pushed to RX with rx_cmd=1.
  - 0x82: the next byte is pushed to RX with rx_cmd=0.
  - 0x83: the device sends one byte in the data phase.
  - Any other code: the code phase is acknowledged, st=10, and the FSM returns to IDLE with no data phase.
- States and transitions:
  - IDLE: on dav_s, latch pa_in as the code, go to C_ACK.
  - C_ACK: ack_n=0. st=00 for a valid code, 10 for an invalid one. On !dav_s, go to C_REL.
  - C_REL: ack_n=1. Go to D_WAIT for a valid code, IDLE for an invalid one.
  - D_WAIT: on dav_s, go to R_ACK for 0x81/0x82 or T_SET for 0x83.
  - R_ACK: latch pa_in. Stall with ack_n=1 while the RX FIFO is full. When there is space, push the byte, set ack_n=0 and st=00. Go to D_REL.
  - T_SET: pa_oe=1. Select the transmit source:
    - TX FIFO head available: pa_out=head, st=11 if its eoi bit is set, else 00; pop the entry on entry to T_SET.
    - TX FIFO empty: pa_out=0x00, st=01, no pop.
    - After SETUP cycles, set ack_n=0 and go to D_REL.
  - D_REL: on !dav_s, set ack_n=1 and pa_oe=0, go to IDLE.
- Timeout: C_ACK, D_WAIT and D_REL each count cycles. When the count reaches TIMEOUT, the FSM goes to IDLE with ack_n=1, pa_oe=0 and st=01. R_ACK stalling on a full RX FIFO is exempt from the timeout.
- st holds its last value until it is next updated.
- FIFOs: 9 bits wide (RX holds cmd tag + 8 data bits; TX holds eoi + 8 data bits). Pointers are DEPTH_LOG2+1 bits; full = MSBs differ and the low bits are equal; wrap-around is natural.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push is accepted only if full was deasserted in that cycle; in practice tx_ready/rx space reflect the current cycle's state.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push succeeds.

## Timing
- Reset values: ack_n=1, pa_oe=0, pa_out=0x00, st=00, busy=0, rx_valid=0, tx_ready=1; both FIFOs empty; FSM in IDLE; synchronizer flops cleared to "DAV high".
- Reset asserted mid-transaction aborts immediately: on the next clock ACK is released and the PA drive is dropped.
- DAV falling at the pin to ack_n=0: 3 cycles for a code phase or a non-stalled receive phase; 3+SETUP cycles for a transmit phase.
- DAV rising at the pin to ack_n=1: 3 cycles. pa_oe falls in the same cycle as ack_n rises.
- RX push to rx_valid=1: 1 cycle.
- TX push visible to a transmit phase: next cycle.

## Test plan
- Reset: hold _reset=0 for 2 cycles -> ack_n=1, pa_oe=0, st=00, rx_valid=0, tx_ready=1.
- Code 0x81, then byte 0x0F -> RX head {cmd=1, 0x0F}; each ACK edge lags its DAV edge by 3 cycles; st=00.
- Preload TX with {0x41, eoi=1}, then code 0x83 -> pa_oe=1, pa_out=0x41, st=11; ack_n falls 3+SETUP cycles after DAV; TX FIFO becomes empty.
- Code 0x83 with TX empty -> pa_out=0x00, st=01, no underflow.
- Send 5 code-0x82 transactions with rx_ready=0 -> the 5th data phase holds ack_n=1. Pulse rx_ready once -> the 5th byte is accepted and ack_n falls.
- Code 0x90 -> acknowledged, st=10, back to IDLE. Separately, leave DAV low past TIMEOUT in C_ACK -> IDLE, ack_n=1, st=01.

Source files
------------

// File: rtl/tcbm_device_link.sv
// Device-side TCBM link: decodes the computer's code/data handshakes on PA/DAV,
// answers with ACK and ST1:ST0, and buffers backend traffic in RX/TX FIFOs.

module tcbm_link_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 9
) (
    input  logic             clock,
    input  logic             _reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is dropped; a push on a full FIFO is refused
    // even if a pop frees a slot in the same cycle.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                     (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_reg[rd_ptr_reg[PW-2:0]];

    always_ff @(posedge clock) begin
        if (!_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_reg[wr_ptr_reg[PW-2:0]] <= wdata;
    end
endmodule

module tcbm_device_link #(
    parameter int DEPTH_LOG2 = 2,
    parameter int SETUP      = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    input  logic       dav_n,
    output logic       ack_n,
    output logic [1:0] st,
    output logic [7:0] rx_data,
    output logic       rx_cmd,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);
    localparam int CMAX = (TIMEOUT > SETUP) ? TIMEOUT : SETUP;
    localparam int CW   = $clog2(CMAX + 1) + 1;

    localparam logic [7:0] CODE_CMD  = 8'h81;
    localparam logic [7:0] CODE_DATA = 8'h82;
    localparam logic [7:0] CODE_SEND = 8'h83;

    typedef enum logic [2:0] {
        S_IDLE, S_C_ACK, S_C_REL, S_D_WAIT, S_R_ACK, S_T_SET, S_D_REL
    } state_t;

    state_t        state_reg;
    logic [7:0]    code_reg;
    logic [CW-1:0] cnt_reg;
    logic          ack_n_reg;
    logic          pa_oe_reg;
    logic [7:0]    pa_out_reg;
    logic [1:0]    st_reg;
    logic          dav_meta_reg;
    logic          dav_sync_reg;
    logic          dav_prev_reg;
    logic          dav_s;
    logic          dav_rise;
    logic          code_is_rx;
    logic          rx_push;
    logic          tx_pop;

    // Index 0 is the RX FIFO (toward backend), index 1 the TX FIFO.
    logic [1:0] f_push;
    logic [1:0] f_pop;
    logic [1:0] f_empty;
    logic [1:0] f_full;
    logic [8:0] f_wdata [2];
    logic [8:0] f_rdata [2];

    function automatic logic code_valid(input logic [7:0] c);
        return (c == CODE_CMD) || (c == CODE_DATA) || (c == CODE_SEND);
    endfunction

    assign dav_s      = ~dav_sync_reg;
    // IDLE starts on a fresh DAV edge so a DAV left low after a timeout abort
    // does not immediately restart a transaction.
    assign dav_rise   = dav_s & ~dav_prev_reg;
    assign code_is_rx = (code_reg == CODE_CMD) || (code_reg == CODE_DATA);

    assign rx_push = ~f_full[0] &
                     (((state_reg == S_D_WAIT) && dav_s && code_is_rx) ||
                      (state_reg == S_R_ACK));
    assign tx_pop  = ~f_empty[1] && (state_reg == S_D_WAIT) && dav_s &&
                     (code_reg == CODE_SEND);

    assign f_push[0]  = rx_push;
    assign f_wdata[0] = {code_reg == CODE_CMD, pa_in};
    assign f_pop[0]   = rx_ready;
    assign f_push[1]  = tx_valid;
    assign f_wdata[1] = {tx_eoi, tx_data};
    assign f_pop[1]   = tx_pop;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            tcbm_link_fifo #(
                .DEPTH_LOG2 (DEPTH_LOG2),
                .WIDTH      (9)
            ) u_fifo (
                .clock  (clock),
                ._reset (_reset),
                .push   (f_push[gi]),
                .wdata  (f_wdata[gi]),
                .pop    (f_pop[gi]),
                .rdata  (f_rdata[gi]),
                .empty  (f_empty[gi]),
                .full   (f_full[gi])
            );
        end
    endgenerate

    assign rx_valid = ~f_empty[0];
    assign rx_cmd   = f_rdata[0][8];
    assign rx_data  = f_rdata[0][7:0];
    assign tx_ready = ~f_full[1];

    assign ack_n  = ack_n_reg;
    assign pa_oe  = pa_oe_reg;
    assign pa_out = pa_out_reg;
    assign st     = st_reg;
    assign busy   = (state_reg != S_IDLE);

    always_ff @(posedge clock) begin
        if (!_reset) begin
            dav_meta_reg <= 1'b1;
            dav_sync_reg <= 1'b1;
            dav_prev_reg <= 1'b0;
        end else begin
            dav_meta_reg <= dav_n;
            dav_sync_reg <= dav_meta_reg;
            dav_prev_reg <= dav_s;
        end
    end

    always_ff @(posedge clock) begin
        if (!_reset) begin
            state_reg  <= S_IDLE;
            code_reg   <= '0;
            cnt_reg    <= '0;
            ack_n_reg  <= 1'b1;
            pa_oe_reg  <= 1'b0;
            pa_out_reg <= '0;
            st_reg     <= 2'b00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (dav_rise) begin
                        code_reg  <= pa_in;
                        ack_n_reg <= 1'b0;
                        st_reg    <= code_valid(pa_in) ? 2'b00 : 2'b10;
                        cnt_reg   <= '0;
                        state_reg <= S_C_ACK;
                    end
                end
                S_C_ACK: begin
                    if (!dav_s) begin
                        ack_n_reg <= 1'b1;
                        state_reg <= S_C_REL;
                    end else if (cnt_reg == CW'(TIMEOUT)) begin
                        ack_n_reg <= 1'b1;
                        pa_oe_reg <= 1'b0;
                        st_reg    <= 2'b01;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_C_REL: begin
                    cnt_reg   <= '0;
                    state_reg <= code_valid(code_reg) ? S_D_WAIT : S_IDLE;
                end
                S_D_WAIT: begin
                    if (dav_s) begin
                        cnt_reg <= '0;
                        if (code_reg == CODE_SEND) begin
                            pa_oe_reg <= 1'b1;
                            if (f_empty[1]) begin
                                pa_out_reg <= 8'h00;
                                st_reg     <= 2'b01;
                            end else begin
                                pa_out_reg <= f_rdata[1][7:0];
                                st_reg     <= f_rdata[1][8] ? 2'b11 : 2'b00;
                            end
                            state_reg <= S_T_SET;
                        end else if (!f_full[0]) begin
                            ack_n_reg <= 1'b0;
                            st_reg    <= 2'b00;
                            state_reg <= S_D_REL;
                        end else begin
                            state_reg <= S_R_ACK;
                        end
                    end else if (cnt_reg == CW'(TIMEOUT)) begin
                        ack_n_reg <= 1'b1;
                        pa_oe_reg <= 1'b0;
                        st_reg    <= 2'b01;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_R_ACK: begin
                    // Stalls indefinitely until the backend frees an RX slot.
                    if (!f_full[0]) begin
                        ack_n_reg <= 1'b0;
                        st_reg    <= 2'b00;
                        cnt_reg   <= '0;
                        state_reg <= S_D_REL;
                    end
                end
                S_T_SET: begin
                    if (cnt_reg == CW'(SETUP - 1)) begin
                        ack_n_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_D_REL;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_D_REL: begin
                    if (!dav_s) begin
                        ack_n_reg <= 1'b1;
                        pa_oe_reg <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (cnt_reg == CW'(TIMEOUT)) begin
                        ack_n_reg <= 1'b1;
                        pa_oe_reg <= 1'b0;
                        st_reg    <= 2'b01;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    ack_n_reg <= 1'b1;
                    pa_oe_reg <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tcbm_device_link.sv
// Randomized scoreboard bench for tcbm_device_link: a computer-side driver
// issues transactions, monitors compare RX pops and transmit bytes to a model.

module tb_tcbm_device_link;
    localparam int SETUP   = 4;
    localparam int TIMEOUT = 40;
    localparam int DEPTH   = 4;

    logic       clock = 1'b0;
    logic       _reset = 1'b0;
    logic [7:0] pa_in = 8'h00;
    logic [7:0] pa_out;
    logic       pa_oe;
    logic       dav_n = 1'b1;
    logic       ack_n;
    logic [1:0] st;
    logic [7:0] rx_data;
    logic       rx_cmd;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_eoi = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit rx_rand = 1'b0;

    logic [8:0] rx_exp [$];   // {cmd, data} expected at the RX head
    logic [9:0] tx_exp [$];   // {st, pa_out} expected at transmit ACK
    logic [8:0] tx_q   [$];   // model of TX FIFO contents {eoi, data}

    logic [7:0] last_out;
    logic [1:0] last_st;
    logic       last_oe;

    tcbm_device_link #(.DEPTH_LOG2(2), .SETUP(SETUP), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), ._reset(_reset), .pa_in(pa_in), .pa_out(pa_out),
        .pa_oe(pa_oe), .dav_n(dav_n), .ack_n(ack_n), .st(st),
        .rx_data(rx_data), .rx_cmd(rx_cmd), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_eoi(tx_eoi),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clock);
        #2;
    endtask

    // One full 4-phase handshake; exp_lat < 0 skips the ACK-fall latency check.
    task automatic phase(input logic [7:0] b, input int exp_lat, input string nm);
        int n;
        @(posedge clock); #2;
        pa_in = b;
        dav_n = 1'b0;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (ack_n !== 1'b0 && n < 200);
        if (ack_n !== 1'b0) check({nm, "_ack_fall_timeout"}, 1, 0);
        else if (exp_lat >= 0) check({nm, "_ack_fall_lat"}, n, exp_lat);
        last_out = pa_out;
        last_st  = st;
        last_oe  = pa_oe;
        @(posedge clock); #2;
        dav_n = 1'b1;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (ack_n !== 1'b1 && n < 200);
        check({nm, "_ack_rise_lat"}, n, 3);
        check({nm, "_oe_drop"}, int'(pa_oe), 0);
    endtask

    task automatic push_tx(input logic [7:0] d, input logic e);
        @(posedge clock); #2;
        tx_data  = d;
        tx_eoi   = e;
        tx_valid = 1'b1;
        check("tx_ready", int'(tx_ready), int'(tx_q.size() < DEPTH));
        if (tx_q.size() < DEPTH) tx_q.push_back({e, d});
        @(posedge clock); #2;
        tx_valid = 1'b0;
        $display("[TB] tx push 0x%02h eoi=%0d model_depth=%0d", d, e, tx_q.size());
    endtask

    task automatic txn(input logic [7:0] code, input logic [7:0] data);
        bit valid;
        logic [8:0] h;
        valid = (code == 8'h81) || (code == 8'h82) || (code == 8'h83);
        phase(code, 3, "code");
        check("code_st", int'(last_st), valid ? 0 : 2);
        if (!valid) begin
            cycles(2);
            check("invalid_idle", int'(busy), 0);
        end else if (code == 8'h83) begin
            if (tx_q.size() == 0) tx_exp.push_back({2'b01, 8'h00});
            else begin
                h = tx_q.pop_front();
                tx_exp.push_back({h[8] ? 2'b11 : 2'b00, h[7:0]});
            end
            phase(data, 3 + SETUP, "tx");
            check("tx_oe", int'(last_oe), 1);
        end else begin
            rx_exp.push_back({code == 8'h81, data});
            phase(data, rx_rand ? -1 : 3, "rx");
            check("rx_st", int'(last_st), 0);
        end
        $display("[TB] txn code=0x%02h data=0x%02h st=%0d out=0x%02h", code, data, last_st, last_out);
    endtask

    // RX monitor: compares the head whenever the backend pops.
    initial forever begin
        @(negedge clock);
        if (_reset && rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) check("rx_unexpected_pop", 1, 0);
            else check("rx_head", int'({rx_cmd, rx_data}), int'(rx_exp.pop_front()));
        end
    end

    // TX monitor: compares PA/ST on each ACK fall while the device drives PA.
    initial begin
        logic ack_prev;
        ack_prev = 1'b1;
        forever begin
            @(negedge clock);
            if (pa_oe && !ack_n && ack_prev) begin
                if (tx_exp.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_byte", int'({st, pa_out}), int'(tx_exp.pop_front()));
            end
            ack_prev = ack_n;
        end
    end

    initial forever begin
        @(posedge clock); #2;
        if (rx_rand) rx_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] c;
        cycles(2);
        #1;
        check("rst_ack_n", int'(ack_n), 1);
        check("rst_pa_oe", int'(pa_oe), 0);
        check("rst_pa_out", int'(pa_out), 0);
        check("rst_st", int'(st), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_tx_ready", int'(tx_ready), 1);
        _reset = 1'b1;
        rx_ready = 1'b1;
        cycles(2);

        txn(8'h81, 8'h0F);
        push_tx(8'h41, 1'b1);
        txn(8'h83, 8'h00);
        txn(8'h83, 8'h00);

        // RX back-pressure: four bytes fill the FIFO, the fifth stalls.
        rx_ready = 1'b0;
        cycles(1);
        for (int i = 0; i < 4; i++) txn(8'h82, 8'(8'hA0 + i));
        phase(8'h82, 3, "stall_code");
        rx_exp.push_back({1'b0, 8'hA4});
        pa_in = 8'hA4;
        dav_n = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (ack_n !== 1'b1) n++;
        end
        check("stall_holds_ack", n, 0);
        @(posedge clock); #2; rx_ready = 1'b1;
        @(posedge clock); #2; rx_ready = 1'b0;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (ack_n !== 1'b0 && n < 10);
        check("stall_release_ack", int'(ack_n), 0);
        @(posedge clock); #2; dav_n = 1'b1;
        cycles(5);
        $display("[TB] txn stalled code=0x82 data=0xa4 accepted after pop");
        rx_ready = 1'b1;
        cycles(10);
        check("rx_drained", int'(rx_valid), 0);

        txn(8'h90, 8'h00);

        // DAV held low past the timeout in C_ACK.
        @(posedge clock); #2;
        pa_in = 8'h81;
        dav_n = 1'b0;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (ack_n !== 1'b0 && n < 20);
        check("to_ack_fall", int'(ack_n), 0);
        cycles(TIMEOUT + 20);
        check("to_ack_n", int'(ack_n), 1);
        check("to_st", int'(st), 1);
        check("to_busy", int'(busy), 0);
        dav_n = 1'b1;
        cycles(6);
        check("to_stays_idle", int'(busy), 0);
        $display("[TB] txn timeout in C_ACK st=%0d", st);

        rx_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                push_tx(8'($urandom), 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 9))
                0, 1, 2: c = 8'h81;
                3, 4, 5: c = 8'h82;
                6, 7, 8: c = 8'h83;
                default: begin
                    do c = 8'($urandom); while (c == 8'h81 || c == 8'h82 || c == 8'h83);
                end
            endcase
            txn(c, 8'($urandom));
        end
        rx_rand = 1'b0;
        rx_ready = 1'b1;
        cycles(20);
        while (tx_q.size() > 0) txn(8'h83, 8'h00);

        // Reset in the middle of a transmit data phase.
        push_tx(8'h5A, 1'b0);
        phase(8'h83, 3, "mr_code");
        tx_exp.push_back({2'b00, 8'h5A});
        void'(tx_q.pop_front());
        @(posedge clock); #2;
        dav_n = 1'b0;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (ack_n !== 1'b0 && n < 30);
        check("mr_ack_low", int'(ack_n), 0);
        @(posedge clock); #2; _reset = 1'b0;
        @(posedge clock); #1;
        check("mr_ack_release", int'(ack_n), 1);
        check("mr_oe_drop", int'(pa_oe), 0);
        #1; dav_n = 1'b1;
        cycles(2);
        _reset = 1'b1;
        cycles(4);
        check("mr_busy", int'(busy), 0);
        $display("[TB] txn reset mid transmit");

        check("rx_exp_left", rx_exp.size(), 0);
        check("tx_exp_left", tx_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
